// File: rtl/rw_out_packer.sv
// Collects the 1-bit output stream of a ReWire device, packs it MSB-first into
// WIDTH-bit words and queues them in a small FIFO behind a valid/ready handshake.
module rw_out_packer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         dev_out,
   input  logic                         dev_continue,
   output logic [WIDTH-1:0]             word_data,
   output logic [$clog2(WIDTH+1)-1:0]   word_bits,
   output logic                         word_last,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic                         overflow,
   output logic                         done
);

   localparam int BW = $clog2(WIDTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [BW-1:0] WIDTH_B = BW'(WIDTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {COLLECT, HALT} state_t;

   state_t           state, stateNext;
   logic [WIDTH-1:0] acc, accNext, accShift;
   logic [BW-1:0]    cnt, cntNext, cntInc;

   logic             push;
   logic [WIDTH-1:0] pushData;
   logic [BW-1:0]    pushBits;
   logic             pushLast;

   logic [WIDTH-1:0] memData [DEPTH];
   logic [BW-1:0]    memBits [DEPTH];
   logic             memLast [DEPTH];
   logic [PW-1:0]    rdPtr, wrPtr;
   logic [CW-1:0]    occ;
   logic             pop, accept;

   // Assembly and halt decision; a partial final word is left-justified so the
   // first sampled bit always lands at the MSB.
   always_comb begin
      stateNext = state;
      accNext   = acc;
      cntNext   = cnt;
      push      = 1'b0;
      pushData  = '0;
      pushBits  = '0;
      pushLast  = 1'b0;
      accShift  = {acc[WIDTH-2:0], dev_out};
      cntInc    = cnt + 1'b1;
      if (state == COLLECT && en) begin
         accNext = accShift;
         cntNext = cntInc;
         if (cntInc == WIDTH_B) begin
            push     = 1'b1;
            pushData = accShift;
            pushBits = WIDTH_B;
            pushLast = ~dev_continue;
            cntNext  = '0;
         end else if (!dev_continue) begin
            push     = 1'b1;
            pushData = accShift << (WIDTH_B - cntInc);
            pushBits = cntInc;
            pushLast = 1'b1;
         end
         if (!dev_continue) stateNext = HALT;
      end
   end

   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign word_valid = (occ != '0);
   assign pop        = word_valid & word_ready;
   assign accept     = push & ((occ != DEPTH_C) | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= COLLECT;
         acc      <= '0;
         cnt      <= '0;
         rdPtr    <= '0;
         wrPtr    <= '0;
         occ      <= '0;
         overflow <= 1'b0;
      end else begin
         state <= stateNext;
         acc   <= accNext;
         cnt   <= cntNext;
         if (pop) rdPtr <= rdPtr + 1'b1;
         if (accept) wrPtr <= wrPtr + 1'b1;
         if (accept && !pop) occ <= occ + 1'b1;
         else if (pop && !accept) occ <= occ - 1'b1;
         if (push && !accept) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible while occupancy covers them.
   always_ff @(posedge clk) begin
      if (accept) begin
         memData[wrPtr] <= pushData;
         memBits[wrPtr] <= pushBits;
         memLast[wrPtr] <= pushLast;
      end
   end

   assign word_data = word_valid ? memData[rdPtr] : '0;
   assign word_bits = word_valid ? memBits[rdPtr] : '0;
   assign word_last = word_valid ? memLast[rdPtr] : 1'b0;
   assign done      = (state == HALT);

endmodule

// File: tb/tb_rw_out_packer.sv
// Self-checking bench for rw_out_packer: a queue-based model of bit packing and
// the word FIFO is compared every cycle, plus hand-computed literal expectations.
module tb_rw_out_packer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dev_out = 1'b0;
   logic       dev_continue = 1'b1;
   logic       word_ready = 1'b0;
   logic [7:0] word_data;
   logic [3:0] word_bits;
   logic       word_last, word_valid, overflow, done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] data;
      int         nbits;
      bit         last;
   } entry_t;

   entry_t fifoQ[$];
   bit     bitQ[$];
   bit     mHalted = 1'b0;
   bit     mOverflow = 1'b0;

   rw_out_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .dev_out(dev_out), .dev_continue(dev_continue),
      .word_data(word_data), .word_bits(word_bits), .word_last(word_last),
      .word_valid(word_valid), .word_ready(word_ready), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge, are sampled at the next one,
   // and en is dropped afterwards so a sample is never repeated by accident.
   task automatic applyStimulus(input bit e, input bit b, input bit c, input bit r);
      en = e;
      dev_out = b;
      dev_continue = c;
      word_ready = r;
      @(posedge clk);
      #2;
      en = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] value, input bit stopAtEnd, input bit r);
      for (int i = 7; i >= 0; i--)
         applyStimulus(1'b1, value[i], !(stopAtEnd && i == 0), r);
   endtask

   // Model: gather bits into a list, emit a word when it is full or the device stops.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fifoQ.delete();
         bitQ.delete();
         mHalted = 1'b0;
         mOverflow = 1'b0;
      end else begin
         bit     doPop, doPush;
         entry_t w;
         doPop = (fifoQ.size() > 0) && word_ready;
         doPush = 1'b0;
         w.data = '0;
         w.nbits = 0;
         w.last = 1'b0;
         if (!mHalted && en) begin
            bitQ.push_back(dev_out);
            if (bitQ.size() == WIDTH || !dev_continue) begin
               foreach (bitQ[i]) w.data[WIDTH-1-i] = bitQ[i];
               w.nbits = bitQ.size();
               w.last = !dev_continue;
               bitQ.delete();
               doPush = 1'b1;
               if (!dev_continue) mHalted = 1'b1;
            end
         end
         if (doPop) void'(fifoQ.pop_front());
         if (doPush) begin
            if (fifoQ.size() < DEPTH) fifoQ.push_back(w);
            else mOverflow = 1'b1;
         end
      end
   end

   // Mid-cycle comparison of every output against the model.
   always @(negedge clk) begin
      bit         v;
      logic [7:0] d;
      int         n;
      bit         l;
      v = fifoQ.size() > 0;
      d = v ? fifoQ[0].data : 8'h00;
      n = v ? fifoQ[0].nbits : 0;
      l = v ? fifoQ[0].last : 1'b0;
      checkOutput("modelValid", {31'b0, word_valid}, {31'b0, v});
      checkOutput("modelData", {24'b0, word_data}, {24'b0, d});
      checkOutput("modelBits", {28'b0, word_bits}, n);
      checkOutput("modelLast", {31'b0, word_last}, {31'b0, l});
      checkOutput("modelOverflow", {31'b0, overflow}, {31'b0, mOverflow});
      checkOutput("modelDone", {31'b0, done}, {31'b0, mHalted});
   end

   task automatic doReset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #2;
      rst = 1'b0;
      checkOutput("resetValid", {31'b0, word_valid}, 0);
      checkOutput("resetDone", {31'b0, done}, 0);
      checkOutput("resetOverflow", {31'b0, overflow}, 0);

      // Full word 1,0,1,1,0,0,1,0
      sendWord(8'hB2, 1'b0, 1'b1);
      checkOutput("t1Valid", {31'b0, word_valid}, 1);
      checkOutput("t1Data", {24'b0, word_data}, 32'hB2);
      checkOutput("t1Bits", {28'b0, word_bits}, 8);
      checkOutput("t1Last", {31'b0, word_last}, 0);
      checkOutput("t1Done", {31'b0, done}, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("t1Popped", {31'b0, word_valid}, 0);

      // Partial final word 1,1,0
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("t2Data", {24'b0, word_data}, 32'hC0);
      checkOutput("t2Bits", {28'b0, word_bits}, 3);
      checkOutput("t2Last", {31'b0, word_last}, 1);
      checkOutput("t2Done", {31'b0, done}, 1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("t2Silent", {31'b0, word_valid}, 0);
      checkOutput("t2StillDone", {31'b0, done}, 1);

      // Single-bit final word as the very first sample
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("oneBitData", {24'b0, word_data}, 32'h80);
      checkOutput("oneBitBits", {28'b0, word_bits}, 1);
      checkOutput("oneBitLast", {31'b0, word_last}, 1);

      // Exactly 16 bits, stop on the last one
      doReset();
      sendWord(8'h5A, 1'b0, 1'b1);
      checkOutput("t3Word1", {24'b0, word_data}, 32'h5A);
      sendWord(8'h3C, 1'b1, 1'b1);
      checkOutput("t3Word2", {24'b0, word_data}, 32'h3C);
      checkOutput("t3Bits2", {28'b0, word_bits}, 8);
      checkOutput("t3Last2", {31'b0, word_last}, 1);
      checkOutput("t3Done", {31'b0, done}, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("t3NoExtra", {31'b0, word_valid}, 0);

      // Stalled consumer, five words into four entries
      doReset();
      for (int k = 0; k < 4; k++) sendWord(8'(8'h11 + k), 1'b0, 1'b0);
      checkOutput("t4NoOvfYet", {31'b0, overflow}, 0);
      sendWord(8'h15, 1'b0, 1'b0);
      checkOutput("t4Overflow", {31'b0, overflow}, 1);
      checkOutput("t4Head", {24'b0, word_data}, 32'h11);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("t4Drain", {24'b0, word_data}, 32'(8'h11 + k));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("t4Empty", {31'b0, word_valid}, 0);
      checkOutput("t4Sticky", {31'b0, overflow}, 1);

      // Full FIFO, completing bit coincides with a pop
      doReset();
      for (int k = 0; k < 4; k++) sendWord(8'(8'h21 + k), 1'b0, 1'b0);
      begin
         logic [7:0] w5;
         w5 = 8'h25;
         for (int i = 7; i >= 1; i--) applyStimulus(1'b1, w5[i], 1'b1, 1'b0);
         applyStimulus(1'b1, w5[0], 1'b1, 1'b1);
      end
      checkOutput("t5NoOverflow", {31'b0, overflow}, 0);
      checkOutput("t5Head", {24'b0, word_data}, 32'h22);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("t5Drain", {24'b0, word_data}, 32'(8'h22 + k));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("t5Empty", {31'b0, word_valid}, 0);

      // Asynchronous reset with two queued words and a 5-bit partial
      doReset();
      sendWord(8'h31, 1'b0, 1'b0);
      sendWord(8'h32, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t6PreValid", {31'b0, word_valid}, 1);
      rst = 1'b1;
      #1;
      checkOutput("t6RstValid", {31'b0, word_valid}, 0);
      checkOutput("t6RstData", {24'b0, word_data}, 0);
      checkOutput("t6RstDone", {31'b0, done}, 0);
      checkOutput("t6RstOverflow", {31'b0, overflow}, 0);
      rst = 1'b0;
      sendWord(8'hA5, 1'b0, 1'b1);
      checkOutput("t6Fresh", {24'b0, word_data}, 32'hA5);
      checkOutput("t6FreshBits", {28'b0, word_bits}, 8);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
